// File: rtl/rram_dig_pkg.sv
// Shared RRAM digital-periphery types: wordline FSM states, default widths, address range check.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rram_dig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } wl_state_t;

    localparam int DEF_Y         = 5;
    localparam int DEF_ROWS      = 32;
    localparam int DEF_PW_W      = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_HOLD_CYC  = 2;

    // True when the encoded address selects one of the physically present lines.
    function automatic logic addr_in_range(input logic [31:0] addr, input int rows);
        return addr < $unsigned(rows);
    endfunction

endpackage

// File: rtl/wl_pulse_decoder_onehot_dec.sv
// Combinational Y-to-ROWS one-hot decoder with enable; the caller registers the result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module onehot_dec #(
    parameter int Y    = 5,
    parameter int ROWS = 32
) (
    input  logic            en,
    input  logic [Y-1:0]    addr,
    output logic [ROWS-1:0] dec
);

    // One line per address value; all lines low when disabled or address unmatched.
    always_comb begin
        dec = '0;
        if (en) begin
            for (int i = 0; i < ROWS; i++) begin
                dec[i] = (addr == Y'(i));
            end
        end
    end

endmodule

// File: rtl/wl_pulse_decoder.sv
// Wordline/bitline pulse decoder: drives one decoded line for a programmed length, framed by setup/hold gaps.
// Latency: done at 1+SETUP_CYC+L+HOLD_CYC cycles after accept (1 cycle for an out-of-range address).
// Backpressure: start/busy handshake; start is ignored while busy. Optional feature macro: DECODER_BROADCAST_EN.
module wl_pulse_decoder
    import rram_dig_pkg::*;
#(
    parameter int Y         = DEF_Y,
    parameter int ROWS      = DEF_ROWS,
    parameter int PW_W      = DEF_PW_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [Y-1:0]    binary_in,
    input  logic [PW_W-1:0] pulse_len,
    input  logic            abort,
    input  logic            broadcast,
    output logic            busy,
    output logic [ROWS-1:0] decoder_out,
    output logic            done,
    output logic            err
);

    // Setup and hold share one phase counter sized for the longer of the two gaps.
    localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(HOLD_CYC - 1);

    wl_state_t       state;
    logic [Y-1:0]    addr_q;
    logic [PW_W-1:0] pulse_cnt;
    logic [PH_W-1:0] phase_cnt;
    logic [ROWS-1:0] dec_line;
    logic [ROWS-1:0] line_vec;
    logic            bcast_q;
    logic            addr_bad;
    logic            in_cmd;

`ifdef DECODER_BROADCAST_EN
    // Broadcast intent is captured with the command and held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            bcast_q <= broadcast;
        end
    end

    assign addr_bad = !broadcast && !addr_in_range(32'(binary_in), ROWS);
`else
    logic unused_broadcast;

    assign unused_broadcast = broadcast;
    assign bcast_q          = 1'b0;
    assign addr_bad         = !addr_in_range(32'(binary_in), ROWS);
`endif

    // Decoder is only consulted on the last setup cycle, when the pulse pattern is loaded.
    onehot_dec #(
        .Y    (Y),
        .ROWS (ROWS)
    ) u_dec (
        .en   (state == ST_SETUP),
        .addr (addr_q),
        .dec  (dec_line)
    );

    assign line_vec = bcast_q ? {ROWS{1'b1}} : dec_line;
    assign in_cmd   = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);

    // Command sequencer; every output is a flop so the driver arrays never see a decode glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            decoder_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            addr_q      <= '0;
            pulse_cnt   <= '0;
            phase_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && in_cmd) begin
                state       <= ST_DONE;
                decoder_out <= '0;
                err         <= 1'b1;
                done        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            addr_q    <= binary_in;
                            // Stored as length-1 so a zero request still yields one pulse cycle.
                            pulse_cnt <= (pulse_len == '0) ? '0 : pulse_len - PW_W'(1);
                            phase_cnt <= SETUP_LD;
                            busy      <= 1'b1;
                            if (addr_bad) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                err   <= 1'b0;
                                state <= ST_SETUP;
                            end
                        end
                    end
                    ST_SETUP: begin
                        if (phase_cnt == '0) begin
                            state       <= ST_PULSE;
                            decoder_out <= line_vec;
                        end else begin
                            phase_cnt <= phase_cnt - PH_W'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (pulse_cnt == '0) begin
                            state       <= ST_HOLD;
                            decoder_out <= '0;
                            phase_cnt   <= HOLD_LD;
                        end else begin
                            pulse_cnt <= pulse_cnt - PW_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (phase_cnt == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt - PH_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        decoder_out <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wl_pulse_decoder.sv
// Bench for wl_pulse_decoder: directed and random commands against a timing-rule reference model.
// Latency: n/a (testbench).
// Backpressure: commands issued while busy are expected to be ignored.
module tb_wl_pulse_decoder;

    localparam int Y    = 5;
    localparam int ROWS = 24;
    localparam int PW_W = 8;
    localparam int S    = 2;
    localparam int H    = 2;

    typedef struct {
        logic [ROWS-1:0] vec;
        int              first;
        int              last;
        int              nhi;
        int              done_rel;
        bit              err;
        bit              err1;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [Y-1:0]    binary_in = '0;
    logic [PW_W-1:0] pulse_len = '0;
    logic            abort = 1'b0;
    logic            broadcast = 1'b0;
    logic            busy;
    logic [ROWS-1:0] decoder_out;
    logic            done;
    logic            err;

    int   cyc = 0;
    int   free_edge = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   idle_leak = 0;
    exp_t sb[$];

    wl_pulse_decoder #(
        .Y         (Y),
        .ROWS      (ROWS),
        .PW_W      (PW_W),
        .SETUP_CYC (S),
        .HOLD_CYC  (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .binary_in   (binary_in),
        .pulse_len   (pulse_len),
        .abort       (abort),
        .broadcast   (broadcast),
        .busy        (busy),
        .decoder_out (decoder_out),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: expected observable result of one accepted command, from the timing rules.
    function automatic exp_t model(input int a, input int len, input bit bc, input int ab);
        exp_t            e;
        int              l;
        bit              bce;
        logic [ROWS-1:0] one;
`ifdef DECODER_BROADCAST_EN
        bce = bc;
`else
        bce = 1'b0;
`endif
        one = 1;
        l   = (len == 0) ? 1 : len;
        e.vec = '0; e.first = 0; e.last = 0; e.nhi = 0; e.err = 1'b0; e.err1 = 1'b0;
        if (!bce && a >= ROWS) begin
            e.done_rel = 1; e.err = 1'b1; e.err1 = 1'b1;
            return e;
        end
        if (ab >= 1 && ab <= S + l + H) begin
            e.done_rel = ab + 1;
            e.err      = 1'b1;
            e.last     = (ab < S + l) ? ab : S + l;
        end else begin
            e.done_rel = 1 + S + l + H;
            e.last     = S + l;
        end
        if (e.last >= S + 1) begin
            e.first = S + 1;
            e.nhi   = e.last - e.first + 1;
            e.vec   = bce ? {ROWS{1'b1}} : (one << a);
        end else begin
            e.last = 0;
        end
        return e;
    endfunction

    // Drive one start for one edge; the model decides whether the DUT should take it.
    task automatic issue(input int a, input int len, input bit bc, input int ab);
        int  acc_edge;
        bit  taken;
        exp_t e;
        acc_edge  = cyc + 1;
        taken     = (acc_edge >= free_edge);
        start     = 1'b1;
        binary_in = a[Y-1:0];
        pulse_len = len[PW_W-1:0];
        broadcast = bc;
        if (taken) begin
            e = model(a, len, bc, ab);
            sb.push_back(e);
            free_edge = acc_edge + e.done_rel + 1;
        end
        @(negedge clk);
        start     = 1'b0;
        broadcast = 1'b0;
        if (taken && ab > 0) begin
            repeat (ab - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) @(negedge clk);
    endtask

    // Monitor: collects each command's line activity and compares against the queue on done.
    int              acc, rel, first, last, nhi;
    bit              active = 1'b0, pend_idle = 1'b0, shape_bad, err1;
    logic [ROWS-1:0] or_vec, first_val;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            active    = 1'b0;
            pend_idle = 1'b0;
        end else begin
            if (pend_idle) begin
                chk("busy_after_done", busy, 0);
                pend_idle = 1'b0;
            end
            if (active && !busy) active = 1'b0;
            if (!active && busy) begin
                active = 1'b1; acc = cyc; or_vec = '0; first_val = '0;
                first = 0; last = 0; nhi = 0; shape_bad = 1'b0; err1 = err;
            end
            if (active) begin
                rel = cyc - acc + 1;
                if (decoder_out != '0) begin
                    if (nhi == 0) first_val = decoder_out;
                    else if (decoder_out != first_val) shape_bad = 1'b1;
                    if (first == 0) first = rel;
                    last = rel;
                    nhi++;
                    or_vec |= decoder_out;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("lines", or_vec, e.vec);
                        chk("first_hi", first, e.first);
                        chk("last_hi", last, e.last);
                        chk("hi_cycles", nhi, e.nhi);
                        chk("shape", shape_bad, 0);
                        chk("done_cycle", rel, e.done_rel);
                        chk("err_at_done", err, e.err);
                        chk("err_at_accept", err1, e.err1);
                    end
                    active    = 1'b0;
                    pend_idle = 1'b1;
                end
            end else if (decoder_out != '0 || done) begin
                idle_leak++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t dummy;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_lines", decoder_out, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(7, 3, 0, 0);   wait_idle();
        issue(30, 5, 0, 0);  wait_idle();
        issue(0, 0, 0, 0);   wait_idle();
        issue(12, 10, 0, 4); wait_idle();
        // start while busy is dropped; start on the done->idle edge is dropped; next edge is taken
        issue(5, 4, 0, 0);
        repeat (2) @(negedge clk);
        issue(9, 1, 0, 0);
        while (cyc + 2 < free_edge) @(negedge clk);
        issue(10, 1, 0, 0);
        issue(6, 2, 0, 0);   wait_idle();
        issue(4, 2, 1, 0);   wait_idle();
        issue(23, 1, 0, 0);  wait_idle();
        issue(24, 1, 0, 0);  wait_idle();
        issue(2, 255, 0, 0); wait_idle();
        issue(8, 3, 0, 1);   wait_idle();
        issue(8, 3, 0, 7);   wait_idle();

        for (int k = 0; k < 40; k++) begin
            int a, len, ab, gap;
            bit bc;
            a   = int'($urandom_range(0, 31));
            len = int'($urandom_range(0, 12));
            bc  = 1'($urandom_range(0, 1));
            ab  = 0;
            if ($urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, S + ((len == 0) ? 1 : len) + H + 2));
            gap = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) wait_idle();
            repeat (gap) @(negedge clk);
            issue(a, len, bc, ab);
        end
        wait_idle();

        // reset in the middle of a pulse drops lines on the same edge with no done
        issue(3, 20, 0, 0);
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        dummy = sb.pop_back();
        @(negedge clk);
        chk("midrst_lines", decoder_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst       = 1'b0;
        free_edge = cyc + 1;
        @(negedge clk);
        issue(11, 2, 0, 0);  wait_idle();

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("idle_lines", idle_leak, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
